// File: rtl/mem_rsp_pkg.sv
// Shared types and constants for the data-memory responder and its byte-lane helper.
//   mem_rsp_state_t : responder FSM state (idle / wait-state countdown / response held)
//   MEM_WORD_BYTES  : byte lanes per memory word
//   MEM_WORD_BITS   : bits per memory word
package mem_rsp_pkg;

  typedef enum logic [1:0] {
    MEM_RSP_IDLE,
    MEM_RSP_WAIT,
    MEM_RSP_RESP
  } mem_rsp_state_t;

  localparam int unsigned MEM_WORD_BYTES = 4;
  localparam int unsigned MEM_WORD_BITS  = 8 * MEM_WORD_BYTES;

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational byte-lane merge: each lane whose enable is set takes the new word's byte,
// every other lane keeps the old word's byte.
//   i_old_word    : current word contents
//   i_new_word    : lane-aligned write data
//   i_be          : byte enables, bit i selects bits [8i+7:8i]
//   o_merged_word : resulting word
module byte_lane_merge
  import mem_rsp_pkg::*;
(
  input  logic [MEM_WORD_BITS-1:0]  i_old_word,
  input  logic [MEM_WORD_BITS-1:0]  i_new_word,
  input  logic [MEM_WORD_BYTES-1:0] i_be,
  output logic [MEM_WORD_BITS-1:0]  o_merged_word
);

  always_comb begin
    o_merged_word = i_old_word;
    for (int unsigned i = 0; i < MEM_WORD_BYTES; i++) begin
      if (i_be[i]) begin
        o_merged_word[8*i +: 8] = i_new_word[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// Memory-side end of the CPU data port: word-addressed RAM behind a valid/ready
// request/response handshake, with a fixed number of wait states and byte-lane stores.
//   clk            : rising-edge clock
//   reset          : asynchronous, active-low; reloads memory from initial_values
//   initial_values : memory image loaded while reset is low
//   req_*          : request channel (valid/ready, write, byte address, data, byte enables)
//   rsp_*          : response channel (valid/ready, read word, out-of-range error)
//   memory_check   : live view of every memory word
module data_memory_responder
  import mem_rsp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 32,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] initial_values [DEPTH_WORDS],
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] memory_check [DEPTH_WORDS]
);

  localparam int unsigned IdxW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DepthIdx = 30'(DEPTH_WORDS);
  localparam logic [3:0]  WaitInit = 4'(WAIT_STATES);
  localparam bit          NoWait   = (WAIT_STATES == 0);

  mem_rsp_state_t r_state;
  mem_rsp_state_t w_state_next;

  logic [3:0]  r_cnt;
  logic        r_write;
  logic [29:0] r_idx;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_accept;
  logic        w_access;
  logic        w_acc_write;
  logic [29:0] w_acc_idx;
  logic [31:0] w_acc_wdata;
  logic [3:0]  w_acc_be;
  logic        w_oob;
  logic [31:0] w_old_word;
  logic [31:0] w_merged;
  logic        w_unused_addr_lsb;

  // Byte offset within the word plays no part in word addressing.
  assign w_unused_addr_lsb = ^req_addr[1:0];

  assign w_accept = (r_state == MEM_RSP_IDLE) && req_valid && reset;

  // With no wait states the access happens on the accepting edge itself, so it must use
  // the live request fields rather than the copies being latched on that same edge.
  assign w_access    = NoWait ? w_accept : ((r_state == MEM_RSP_WAIT) && (r_cnt == 4'd1));
  assign w_acc_write = NoWait ? req_write       : r_write;
  assign w_acc_idx   = NoWait ? req_addr[31:2]  : r_idx;
  assign w_acc_wdata = NoWait ? req_wdata       : r_wdata;
  assign w_acc_be    = NoWait ? req_be          : r_be;

  assign w_oob      = (w_acc_idx >= DepthIdx);
  assign w_old_word = w_oob ? '0 : r_mem[w_acc_idx[IdxW-1:0]];

  byte_lane_merge u_byte_lane_merge (
    .i_old_word    (w_old_word),
    .i_new_word    (w_acc_wdata),
    .i_be          (w_acc_be),
    .o_merged_word (w_merged)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= MEM_RSP_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      MEM_RSP_IDLE: begin
        if (w_accept) begin
          w_state_next = NoWait ? MEM_RSP_RESP : MEM_RSP_WAIT;
        end
      end
      MEM_RSP_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_state_next = MEM_RSP_RESP;
        end
      end
      MEM_RSP_RESP: begin
        if (rsp_ready) begin
          w_state_next = MEM_RSP_IDLE;
        end
      end
      default: w_state_next = MEM_RSP_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_ready = (r_state == MEM_RSP_IDLE) && reset;
    rsp_valid = (r_state == MEM_RSP_RESP);
  end

  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  // Request capture, wait-state counter and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write <= req_write;
        r_idx   <= req_addr[31:2];
        r_wdata <= req_wdata;
        r_be    <= req_be;
        r_cnt   <= WaitInit;
      end else if (r_state == MEM_RSP_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end

      if (w_access) begin
        r_err <= w_oob;
        if (w_oob) begin
          r_rdata <= '0;
        end else if (w_acc_write) begin
          r_rdata <= w_merged;
        end else begin
          r_rdata <= w_old_word;
        end
      end else if ((r_state == MEM_RSP_RESP) && rsp_ready) begin
        r_err <= 1'b0;
      end
    end
  end

  // Storage: reloaded from the image while in reset, otherwise written only on a
  // store access that lands inside the array.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
        r_mem[i] <= initial_values[i];
      end
    end else if (w_access && w_acc_write && !w_oob) begin
      r_mem[w_acc_idx[IdxW-1:0]] <= w_merged;
    end
  end

  assign memory_check = r_mem;

endmodule

// File: tb/tb_data_memory_responder.sv
module tb_data_memory_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] init_vals [32];

  // Instance A: two wait states
  logic        a_req_valid, a_req_ready, a_req_write, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic [3:0]  a_req_be;
  logic [31:0] a_mem [32];

  // Instance B: zero wait states
  logic        b_req_valid, b_req_ready, b_req_write, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [3:0]  b_req_be;
  logic [31:0] b_mem [32];

  // Reference memory images
  logic [31:0] ref_a [32];
  logic [31:0] ref_b [32];

  int total = 0;
  int bad   = 0;

  data_memory_responder #(.DEPTH_WORDS(32), .WAIT_STATES(2)) u_dut_a (
    .clk            (clk),
    .reset          (reset),
    .initial_values (init_vals),
    .req_valid      (a_req_valid),
    .req_ready      (a_req_ready),
    .req_write      (a_req_write),
    .req_addr       (a_req_addr),
    .req_wdata      (a_req_wdata),
    .req_be         (a_req_be),
    .rsp_valid      (a_rsp_valid),
    .rsp_ready      (a_rsp_ready),
    .rsp_rdata      (a_rsp_rdata),
    .rsp_err        (a_rsp_err),
    .memory_check   (a_mem)
  );

  data_memory_responder #(.DEPTH_WORDS(32), .WAIT_STATES(0)) u_dut_b (
    .clk            (clk),
    .reset          (reset),
    .initial_values (init_vals),
    .req_valid      (b_req_valid),
    .req_ready      (b_req_ready),
    .req_write      (b_req_write),
    .req_addr       (b_req_addr),
    .req_wdata      (b_req_wdata),
    .req_be         (b_req_be),
    .rsp_valid      (b_rsp_valid),
    .rsp_ready      (b_rsp_ready),
    .rsp_rdata      (b_rsp_rdata),
    .rsp_err        (b_rsp_err),
    .memory_check   (b_mem)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: a word array updated by plain mask arithmetic.
  task automatic model_op(input bit sel, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          output logic [31:0] exp_rd, output logic exp_err);
    int unsigned idx;
    logic [31:0] mask;
    logic [31:0] word;
    idx = addr >> 2;
    if (idx >= 32) begin
      exp_rd  = 32'h0;
      exp_err = 1'b1;
    end else begin
      word    = sel ? ref_b[idx] : ref_a[idx];
      exp_err = 1'b0;
      if (wr) begin
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        word = (word & ~mask) | (wdata & mask);
        if (sel) ref_b[idx] = word;
        else     ref_a[idx] = word;
      end
      exp_rd = word;
    end
  endtask

  // Drives one request, measures edges from accept to rsp_valid, holds the response for
  // 'hold' extra cycles and then completes it. lat = -1 on timeout.
  task automatic issue(input bit sel, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input int hold,
                       output logic [31:0] rd, output logic err, output int lat);
    if (sel) begin
      b_req_valid = 1'b1; b_req_write = wr; b_req_addr = addr; b_req_wdata = wdata;
      b_req_be = be;
    end else begin
      a_req_valid = 1'b1; a_req_write = wr; a_req_addr = addr; a_req_wdata = wdata;
      a_req_be = be;
    end
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    lat = 0;
    while (!(sel ? b_rsp_valid : a_rsp_valid) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 40) lat = -1;
    rd  = sel ? b_rsp_rdata : a_rsp_rdata;
    err = sel ? b_rsp_err : a_rsp_err;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    if (sel) b_rsp_ready = 1'b1;
    else     a_rsp_ready = 1'b1;
    @(posedge clk); #1;
    a_rsp_ready = 1'b0;
    b_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    int nmis;
    reset = 1'b0;
    a_req_valid = 0; a_req_write = 0; a_req_addr = 0; a_req_wdata = 0; a_req_be = 0;
    a_rsp_ready = 0;
    b_req_valid = 0; b_req_write = 0; b_req_addr = 0; b_req_wdata = 0; b_req_be = 0;
    b_rsp_ready = 0;
    for (int i = 0; i < 32; i++) init_vals[i] = $urandom;
    init_vals[3] = 32'hDEADBEEF;
    init_vals[0] = $urandom | 32'h0000_0100;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (a_req_ready !== 1'b0) begin
      bad++; $display("FAIL reset_req_ready_low got=%b exp=0", a_req_ready);
    end
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ref_a[i] = init_vals[i];
      ref_b[i] = init_vals[i];
    end
    #1;
    total++;
    if (a_mem[3] !== 32'hDEADBEEF) begin
      bad++; $display("FAIL reset_mem3 got=%h exp=deadbeef", a_mem[3]);
    end
    total++;
    if (a_req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_req_ready got=%b exp=1", a_req_ready);
    end
    total++;
    if (a_rsp_valid !== 1'b0 || a_rsp_err !== 1'b0 || a_rsp_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_rsp got valid=%b err=%b rdata=%h exp 0/0/0", a_rsp_valid, a_rsp_err,
               a_rsp_rdata);
    end
    nmis = 0;
    for (int i = 0; i < 32; i++) if (a_mem[i] !== ref_a[i] || b_mem[i] !== ref_b[i]) nmis++;
    total++;
    if (nmis != 0) begin
      bad++; $display("FAIL reset_image got=%0d mismatching words exp=0", nmis);
    end
  endtask

  task automatic test_load_latency();
    logic [31:0] rd, exp_rd;
    logic err, exp_err;
    int lat;
    total++;
    if (a_req_ready !== 1'b1) begin
      bad++; $display("FAIL load_req_ready got=%b exp=1", a_req_ready);
    end
    issue(1'b0, 1'b0, 32'h0000_000C, $urandom, 4'($urandom), 0, rd, err, lat);
    model_op(1'b0, 1'b0, 32'h0000_000C, 32'h0, 4'h0, exp_rd, exp_err);
    total++;
    if (lat != 2) begin
      bad++; $display("FAIL load_latency got=%0d exp=2", lat);
    end
    total++;
    if (rd !== 32'hDEADBEEF || rd !== exp_rd) begin
      bad++; $display("FAIL load_rdata got=%h exp=deadbeef", rd);
    end
    total++;
    if (err !== exp_err) begin
      bad++; $display("FAIL load_err got=%b exp=%b", err, exp_err);
    end
  endtask

  task automatic test_byte_store();
    logic [31:0] rd, exp_rd;
    logic err, exp_err;
    int lat;
    issue(1'b0, 1'b1, 32'h0000_000C, 32'h0000_AA00, 4'b0010, 0, rd, err, lat);
    model_op(1'b0, 1'b1, 32'h0000_000C, 32'h0000_AA00, 4'b0010, exp_rd, exp_err);
    total++;
    if (rd !== 32'hDEADAAEF || rd !== exp_rd || err !== 1'b0) begin
      bad++; $display("FAIL byte_store_rdata got=%h/%b exp=deadaaef/0", rd, err);
    end
    total++;
    if (a_mem[3] !== 32'hDEADAAEF) begin
      bad++; $display("FAIL byte_store_mem got=%h exp=deadaaef", a_mem[3]);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_rd;
    logic exp_err;
    int lat;
    int nviol;
    model_op(1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, exp_rd, exp_err);
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 32'h10; a_req_be = 4'hF;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    lat = 0;
    while (!a_rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (lat != 2) begin
      bad++; $display("FAIL bp_latency got=%0d exp=2", lat);
    end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== exp_rd || a_req_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold cycle=%0d got valid=%b rdata=%h ready=%b exp 1/%h/0", k,
                 a_rsp_valid, a_rsp_rdata, a_req_ready, exp_rd);
      end
      if (k == 1) begin
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 32'h0;
        a_req_wdata = ~ref_a[0]; a_req_be = 4'hF;
      end
      if (k == 2) a_req_valid = 1'b0;
      @(posedge clk); #1;
    end
    a_rsp_ready = 1'b1;
    @(posedge clk); #1;
    a_rsp_ready = 1'b0;
    total++;
    if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release got valid=%b ready=%b exp 0/1", a_rsp_valid, a_req_ready);
    end
    nviol = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (a_rsp_valid !== 1'b0) nviol++;
    end
    total++;
    if (nviol != 0 || a_mem[0] !== ref_a[0]) begin
      bad++;
      $display("FAIL bp_pulse_ignored got valid_cycles=%0d mem0=%h exp 0/%h", nviol, a_mem[0],
               ref_a[0]);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd, exp_rd;
    logic err, exp_err;
    int lat;
    int nmis;
    issue(1'b0, 1'b1, 32'h0000_0080, $urandom, 4'hF, 1, rd, err, lat);
    model_op(1'b0, 1'b1, 32'h0000_0080, 32'h0, 4'hF, exp_rd, exp_err);
    total++;
    if (err !== 1'b1 || rd !== 32'h0 || err !== exp_err) begin
      bad++; $display("FAIL oob_store got err=%b rdata=%h exp 1/0", err, rd);
    end
    nmis = 0;
    for (int i = 0; i < 32; i++) if (a_mem[i] !== ref_a[i]) nmis++;
    total++;
    if (nmis != 0) begin
      bad++; $display("FAIL oob_mem_unchanged got=%0d changed words exp=0", nmis);
    end
    total++;
    if (a_rsp_err !== 1'b0) begin
      bad++; $display("FAIL oob_err_cleared got=%b exp=0", a_rsp_err);
    end
    issue(1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0, 4'h0, 0, rd, err, lat);
    total++;
    if (err !== 1'b1 || rd !== 32'h0) begin
      bad++; $display("FAIL oob_load got err=%b rdata=%h exp 1/0", err, rd);
    end
  endtask

  task automatic test_random(input bit sel, input int n);
    logic [31:0] rd, exp_rd, addr, wdata;
    logic err, exp_err, wr;
    logic [3:0] be;
    int lat, nmis, exp_lat;
    int unsigned idx;
    exp_lat = sel ? 0 : 2;
    for (int t = 0; t < n; t++) begin
      wr    = 1'($urandom_range(0, 1));
      idx   = ($urandom_range(0, 9) == 0) ? ($urandom >> 2) : $urandom_range(0, 31);
      addr  = (idx << 2) | $urandom_range(0, 3);
      wdata = $urandom;
      be    = 4'($urandom_range(0, 15));
      total++;
      if ((sel ? b_req_ready : a_req_ready) !== 1'b1) begin
        bad++; $display("FAIL rand_ready sel=%0d txn=%0d got=0 exp=1", sel, t);
      end
      issue(sel, wr, addr, wdata, be, $urandom_range(0, 3), rd, err, lat);
      model_op(sel, wr, addr, wdata, be, exp_rd, exp_err);
      total++;
      if (lat != exp_lat) begin
        bad++; $display("FAIL rand_latency sel=%0d txn=%0d got=%0d exp=%0d", sel, t, lat, exp_lat);
      end
      total++;
      if (rd !== exp_rd || err !== exp_err) begin
        bad++;
        $display("FAIL rand_rsp sel=%0d txn=%0d addr=%h wr=%b be=%b got=%h/%b exp=%h/%b", sel, t,
                 addr, wr, be, rd, err, exp_rd, exp_err);
      end
      nmis = 0;
      for (int i = 0; i < 32; i++) begin
        if (sel ? (b_mem[i] !== ref_b[i]) : (a_mem[i] !== ref_a[i])) nmis++;
      end
      total++;
      if (nmis != 0) begin
        bad++; $display("FAIL rand_mem sel=%0d txn=%0d got=%0d wrong words exp=0", sel, t, nmis);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    int nviol;
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 32'h0;
    a_req_wdata = 32'h0000_0001; a_req_be = 4'hF;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    total++;
    if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b0 || a_rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL midwait_outputs got valid=%b ready=%b err=%b exp 0/0/0", a_rsp_valid,
               a_req_ready, a_rsp_err);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ref_a[i] = init_vals[i];
      ref_b[i] = init_vals[i];
    end
    #1;
    total++;
    if (a_req_ready !== 1'b1) begin
      bad++; $display("FAIL midwait_ready got=%b exp=1", a_req_ready);
    end
    nviol = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (a_rsp_valid !== 1'b0) nviol++;
    end
    total++;
    if (nviol != 0) begin
      bad++; $display("FAIL midwait_no_rsp got=%0d valid cycles exp=0", nviol);
    end
    total++;
    if (a_mem[0] !== init_vals[0]) begin
      bad++; $display("FAIL midwait_mem0 got=%h exp=%h", a_mem[0], init_vals[0]);
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] rd, exp_rd;
    logic err, exp_err;
    int lat;
    total++;
    if (b_req_ready !== 1'b1) begin
      bad++; $display("FAIL zw_ready got=%b exp=1", b_req_ready);
    end
    issue(1'b1, 1'b0, 32'h0000_000C, 32'h0, 4'hF, 0, rd, err, lat);
    model_op(1'b1, 1'b0, 32'h0000_000C, 32'h0, 4'hF, exp_rd, exp_err);
    total++;
    if (lat != 0) begin
      bad++; $display("FAIL zw_latency got=%0d exp=0", lat);
    end
    total++;
    if (rd !== 32'hDEADBEEF || rd !== exp_rd || err !== 1'b0) begin
      bad++; $display("FAIL zw_rdata got=%h/%b exp=deadbeef/0", rd, err);
    end
  endtask

  initial begin
    test_reset();
    test_load_latency();
    test_byte_store();
    test_backpressure();
    test_out_of_range();
    test_random(1'b0, 30);
    test_reset_mid_wait();
    test_zero_wait();
    test_random(1'b1, 20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
